// File: rtl/rom_map_pkg.sv
// -----------------------------------------------------------------------------
// rom_map_pkg
// Shared loader region map for the EPROM/RAM dprams. The download selector and
// the upload readback path both decode the 25-bit ioctl address against these
// tables.
//   REGION_BASE / REGION_SIZE_LOG2 : per-region byte base and log2(size)
//   region_t                       : region index, in RB_CS bit order
//   OOR_INDEX                      : index reported for out-of-range addresses
//   rb_state_t                     : readback FSM states
// -----------------------------------------------------------------------------
package rom_map_pkg;

    localparam int ADDR_W    = 25;
    localparam int OFFS_W    = 15;
    localparam int REGIONS_C = 14;

    typedef enum logic [3:0] {
        REGION_EP1  = 4'd0,
        REGION_EP2  = 4'd1,
        REGION_EP9  = 4'd2,
        REGION_EP3  = 4'd3,
        REGION_EP4  = 4'd4,
        REGION_EP5  = 4'd5,
        REGION_EP6  = 4'd6,
        REGION_EP7  = 4'd7,
        REGION_EP8  = 4'd8,
        REGION_EP10 = 4'd9,
        REGION_EP11 = 4'd10,
        REGION_EP12 = 4'd11,
        REGION_EP13 = 4'd12,
        REGION_EP14 = 4'd13,
        REGION_OOR  = 4'd14
    } region_t;

    localparam region_t OOR_INDEX = REGION_OOR;

    localparam logic [ADDR_W-1:0] REGION_BASE [REGIONS_C] = '{
        25'h00000, 25'h08000, 25'h10000, 25'h12000, 25'h14000,
        25'h16000, 25'h1E000, 25'h26000, 25'h2E000, 25'h36000,
        25'h3E000, 25'h46000, 25'h4E000, 25'h56000
    };

    localparam int REGION_SIZE_LOG2 [REGIONS_C] = '{
        15, 15, 13, 13, 13,
        15, 15, 15, 15, 15,
        15, 15, 15, 15
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        LAT     = 2'd2,
        PRESENT = 2'd3
    } rb_state_t;

endpackage

// File: rtl/rom_region_decode.sv
// -----------------------------------------------------------------------------
// rom_region_decode
// Combinational loader-address decoder shared by download and upload paths.
//   addr   in  25  byte address in the loader map
//   region out 4   region index (OOR_INDEX when outside every region)
//   oor    out 1   address lies outside every region
//   offset out 15  region-local offset (zero when out of range)
// -----------------------------------------------------------------------------
module rom_region_decode
    import rom_map_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic              oor,
    output logic [OFFS_W-1:0] offset
);

    // Regions never overlap, so at most one iteration matches.
    always_comb begin
        region = OOR_INDEX;
        oor    = 1'b1;
        offset = '0;
        for (int i = 0; i < REGIONS_C; i++) begin
            if ((addr >= REGION_BASE[i]) &&
                (addr <  REGION_BASE[i] + (25'd1 << REGION_SIZE_LOG2[i]))) begin
                region = region_t'(4'(i));
                oor    = 1'b0;
                offset = OFFS_W'(addr - REGION_BASE[i]);
            end
        end
    end

endmodule

// File: rtl/rom_readback.sv
// -----------------------------------------------------------------------------
// rom_readback
// Serves HPS ioctl upload reads by reading the EPROM/RAM dprams back through
// their download-side port b. One byte per IOCTL_RD, held off with IOCTL_WAIT.
//   CLK_DL        in   1              download/upload clock
//   RESET         in   1              synchronous, active-high reset
//   IOCTL_UPLOAD  in   1              upload session active
//   IOCTL_RD      in   1              single-cycle read strobe
//   IOCTL_ADDR    in   25             byte address in the loader map
//   IOCTL_DIN     out  8              returned byte
//   IOCTL_WAIT    out  1              high while a read is outstanding
//   RB_CS         out  NUM_REGIONS    one-hot region read select
//   RB_ADDR       out  15             region-local offset
//   RB_DATA       in   8*NUM_REGIONS  port-b read data, region i at [8i+7:8i]
//   CHECKSUM      out  16             (ROM_READBACK_CHECKSUM_EN only) running
//                                     sum of bytes presented this session
// Optional feature macro: ROM_READBACK_CHECKSUM_EN
// -----------------------------------------------------------------------------
module rom_readback
    import rom_map_pkg::*;
#(
    parameter int         NUM_REGIONS = 14,
    parameter int         RD_LATENCY  = 1,
    parameter logic [7:0] OOR_DATA    = 8'hFF
) (
    input  logic                     CLK_DL,
    input  logic                     RESET,
    input  logic                     IOCTL_UPLOAD,
    input  logic                     IOCTL_RD,
    input  logic [24:0]              IOCTL_ADDR,
    output logic [7:0]               IOCTL_DIN,
    output logic                     IOCTL_WAIT,
    output logic [NUM_REGIONS-1:0]   RB_CS,
    output logic [14:0]              RB_ADDR,
    input  logic [8*NUM_REGIONS-1:0] RB_DATA
`ifdef ROM_READBACK_CHECKSUM_EN
    ,
    output logic [15:0]              CHECKSUM
`endif
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY);

    rb_state_t         state, state_nxt;
    region_t           dec_region;
    logic              dec_oor;
    logic [OFFS_W-1:0] dec_offset;

    logic [3:0]        region_p0, region_nxt;
    logic              oor_p0, oor_nxt;
    logic [OFFS_W-1:0] offset_p0, offset_nxt;

    logic [1:0]        lat_cnt, lat_nxt;
    logic [7:0]        din_nxt;
    logic              wait_nxt;
    logic [NUM_REGIONS-1:0] cs_nxt;
    logic [14:0]       addr_nxt;
    logic [7:0]        sel_byte;

    rom_region_decode u_decode (
        .addr   (IOCTL_ADDR),
        .region (dec_region),
        .oor    (dec_oor),
        .offset (dec_offset)
    );

    function automatic logic [NUM_REGIONS-1:0] region_onehot(input logic [3:0] idx,
                                                             input logic       is_oor);
        logic [NUM_REGIONS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            oh[i] = !is_oor && (idx == 4'(i));
        end
        return oh;
    endfunction

    // Byte from the latched region; out-of-range requests read the fill value.
    always_comb begin
        sel_byte = OOR_DATA;
        if (!oor_p0) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (region_p0 == 4'(i)) begin
                    sel_byte = RB_DATA[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        region_nxt = region_p0;
        oor_nxt    = oor_p0;
        offset_nxt = offset_p0;
        lat_nxt    = lat_cnt;
        din_nxt    = IOCTL_DIN;
        wait_nxt   = IOCTL_WAIT;
        cs_nxt     = RB_CS;
        addr_nxt   = RB_ADDR;

        // Losing the upload session abandons an outstanding read; the last
        // delivered byte stays on IOCTL_DIN.
        if ((state != IDLE) && !IOCTL_UPLOAD) begin
            state_nxt = IDLE;
            wait_nxt  = 1'b0;
            cs_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IOCTL_RD && IOCTL_UPLOAD) begin
                        region_nxt = dec_region;
                        oor_nxt    = dec_oor;
                        offset_nxt = dec_offset;
                        wait_nxt   = 1'b1;
                        state_nxt  = ISSUE;
                    end
                end
                ISSUE: begin
                    cs_nxt    = region_onehot(region_p0, oor_p0);
                    addr_nxt  = offset_p0;
                    lat_nxt   = LAT_INIT;
                    state_nxt = LAT;
                end
                LAT: begin
                    lat_nxt = lat_cnt - 2'd1;
                    if (lat_cnt <= 2'd1) begin
                        state_nxt = PRESENT;
                    end
                end
                PRESENT: begin
                    din_nxt   = sel_byte;
                    wait_nxt  = 1'b0;
                    cs_nxt    = '0;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // ---- request latch (p0) and output registers ----
    always_ff @(posedge CLK_DL) begin
        region_p0 <= region_nxt;
        oor_p0    <= oor_nxt;
        offset_p0 <= offset_nxt;
        if (RESET) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            IOCTL_DIN  <= '0;
            IOCTL_WAIT <= 1'b0;
            RB_CS      <= '0;
            RB_ADDR    <= '0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_nxt;
            IOCTL_DIN  <= din_nxt;
            IOCTL_WAIT <= wait_nxt;
            RB_CS      <= cs_nxt;
            RB_ADDR    <= addr_nxt;
        end
    end

`ifdef ROM_READBACK_CHECKSUM_EN
    logic upload_q;
    logic present;

    // A byte is delivered only when PRESENT completes without an abort.
    assign present = (state == PRESENT) && IOCTL_UPLOAD;

    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [7:0] b);
        return acc + {8'h00, b};
    endfunction

    always_ff @(posedge CLK_DL) begin
        if (RESET) begin
            upload_q <= 1'b0;
            CHECKSUM <= '0;
        end else begin
            upload_q <= IOCTL_UPLOAD;
            if (IOCTL_UPLOAD && !upload_q) begin
                CHECKSUM <= '0;
            end else if (present && !oor_p0) begin
                CHECKSUM <= csum_add(CHECKSUM, sel_byte);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_readback.sv
module tb_rom_readback;

`ifdef ROM_READBACK_CHECKSUM_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam int NREG = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              upload;
    logic              rd;
    logic [24:0]       addr;
    logic [7:0]        din;
    logic              wt;
    logic [NREG-1:0]   cs;
    logic [14:0]       rb_addr;
    logic [8*NREG-1:0] rb_data;
`ifdef ROM_READBACK_CHECKSUM_EN
    logic [15:0]       csum;
`endif

    int checks = 0;
    int errors = 0;
    int wait_rises = 0;
    logic wt_q = 1'b0;
    logic [7:0] last_din;

    logic [7:0]        mem  [NREG][32768];
    logic [8*NREG-1:0] pipe [3];

    rom_readback #(
        .NUM_REGIONS (NREG),
        .RD_LATENCY  (RD_LAT),
        .OOR_DATA    (8'hFF)
    ) dut (
        .CLK_DL       (clk),
        .RESET        (rst),
        .IOCTL_UPLOAD (upload),
        .IOCTL_RD     (rd),
        .IOCTL_ADDR   (addr),
        .IOCTL_DIN    (din),
        .IOCTL_WAIT   (wt),
        .RB_CS        (cs),
        .RB_ADDR      (rb_addr),
        .RB_DATA      (rb_data)
`ifdef ROM_READBACK_CHECKSUM_EN
        ,
        .CHECKSUM     (csum)
`endif
    );

    always #5 clk = ~clk;

    // Port-b dpram model with RD_LAT cycles of read latency.
    always @(posedge clk) begin : dpram_b
        logic [8*NREG-1:0] t;
        for (int i = 0; i < NREG; i++) begin
            t[8*i +: 8] = mem[i][rb_addr];
        end
        pipe[0] <= t;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign rb_data = pipe[RD_LAT-1];

    always @(negedge clk) begin
        if (wt === 1'b1 && wt_q !== 1'b1) wait_rises++;
        wt_q = wt;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [24:0] a,
                           input logic [NREG-1:0] exp_cs, input logic [14:0] exp_off,
                           input logic [7:0] exp_din);
        int k;
        logic [NREG-1:0] seen;
        @(negedge clk); rd = 1'b1; addr = a;
        @(negedge clk); rd = 1'b0;
        check({tag, "_wait_hi"}, 32'(wt), 32'd1);
        k = 0;
        seen = '0;
        while (wt === 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
            seen |= cs;
            if (k == 1) begin
                check({tag, "_cs"}, 32'(cs), 32'(exp_cs));
                check({tag, "_rbaddr"}, 32'(rb_addr), 32'(exp_off));
            end
        end
        check({tag, "_latency"}, 32'(k), 32'(2 + RD_LAT));
        check({tag, "_din"}, 32'(din), 32'(exp_din));
        check({tag, "_cs_seen"}, 32'(seen), 32'(exp_cs));
        check({tag, "_cs_clear"}, 32'(cs), 32'd0);
        check({tag, "_rbaddr_hold"}, 32'(rb_addr), 32'(exp_off));
        last_din = exp_din;
    endtask

    initial begin
        int k;
        int r0;
        logic [NREG-1:0] seen;

        for (int r = 0; r < NREG; r++)
            for (int o = 0; o < 32768; o++)
                mem[r][o] = 8'h00;
        mem[0][16'h0010]  = 8'h3C;
        mem[3][16'h0005]  = 8'hA7;
        mem[2][16'h1FFF]  = 8'h5A;
        mem[13][16'h7FFF] = 8'h81;
        mem[0][16'h0000]  = 8'h11;
        mem[1][16'h0004]  = 8'h99;
        mem[5][16'h0020]  = 8'h77;
        mem[0][16'h0100]  = 8'hFF;
        mem[0][16'h0101]  = 8'h02;
        mem[0][16'h0102]  = 8'h10;

        rst = 1'b1; upload = 1'b0; rd = 1'b0; addr = '0; last_din = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_din", 32'(din), 32'd0);
        check("rst_wait", 32'(wt), 32'd0);
        check("rst_cs", 32'(cs), 32'd0);
        check("rst_rbaddr", 32'(rb_addr), 32'd0);
`ifdef ROM_READBACK_CHECKSUM_EN
        check("rst_csum", 32'(csum), 32'd0);
`endif

        // Read strobe without an upload session is ignored.
        @(negedge clk); rd = 1'b1; addr = 25'h00010;
        @(negedge clk); rd = 1'b0;
        check("noupl_wait", 32'(wt), 32'd0);
        @(negedge clk);
        check("noupl_cs", 32'(cs), 32'd0);
        check("noupl_din", 32'(din), 32'd0);

        upload = 1'b1;
        @(negedge clk);

        do_read("ep1",      25'h00010, 14'h0001, 15'h0010, 8'h3C);
        do_read("ep3",      25'h12005, 14'h0008, 15'h0005, 8'hA7);
        do_read("ep9_top",  25'h11FFF, 14'h0004, 15'h1FFF, 8'h5A);
        do_read("ep14_top", 25'h5DFFF, 14'h2000, 15'h7FFF, 8'h81);
        do_read("oor",      25'h5E000, 14'h0000, 15'h0000, 8'hFF);

        // Second strobe while busy must not disturb the first request.
        r0 = wait_rises;
        @(negedge clk); rd = 1'b1; addr = 25'h00000;
        @(negedge clk); addr = 25'h08004;
        @(negedge clk); rd = 1'b0;
        seen = cs;
        k = 0;
        while (wt === 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
            seen |= cs;
        end
        check("busy_latency", 32'(k), 32'(RD_LAT + 1));
        check("busy_din", 32'(din), 32'h11);
        check("busy_cs_seen", 32'(seen), 32'h0001);
        check("busy_rbaddr", 32'(rb_addr), 32'h0000);
        repeat (4) @(negedge clk);
        check("busy_wait_pulses", 32'(wait_rises - r0), 32'd1);
        last_din = 8'h11;

        // Upload drops while the request waits on the dpram.
        @(negedge clk); rd = 1'b1; addr = 25'h16020;
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        check("abort_cs_pre", 32'(cs), 32'h0020);
        upload = 1'b0;
        @(negedge clk);
        check("abort_wait", 32'(wt), 32'd0);
        check("abort_cs", 32'(cs), 32'd0);
        check("abort_din", 32'(din), 32'(last_din));
        upload = 1'b1;
        @(negedge clk);
        check("abort_idle", 32'(wt), 32'd0);

        do_read("after_abort", 25'h16020, 14'h0020, 15'h0020, 8'h77);

        // Reset in the middle of a request.
        @(negedge clk); rd = 1'b1; addr = 25'h12005;
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_din", 32'(din), 32'd0);
        check("mrst_wait", 32'(wt), 32'd0);
        check("mrst_cs", 32'(cs), 32'd0);
        check("mrst_rbaddr", 32'(rb_addr), 32'd0);
        @(negedge clk);
        check("mrst_idle", 32'(wt), 32'd0);

        do_read("after_rst", 25'h00010, 14'h0001, 15'h0010, 8'h3C);

`ifdef ROM_READBACK_CHECKSUM_EN
        upload = 1'b0;
        @(negedge clk); upload = 1'b1;
        @(negedge clk);
        check("csum_new_session", 32'(csum), 32'd0);
        do_read("cs_b0", 25'h00100, 14'h0001, 15'h0100, 8'hFF);
        do_read("cs_b1", 25'h00101, 14'h0001, 15'h0101, 8'h02);
        do_read("cs_oor", 25'h5E010, 14'h0000, 15'h0000, 8'hFF);
        do_read("cs_b2", 25'h00102, 14'h0001, 15'h0102, 8'h10);
        check("csum_sum", 32'(csum), 32'h0111);
        upload = 1'b0;
        @(negedge clk); upload = 1'b1;
        @(negedge clk);
        check("csum_cleared", 32'(csum), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
